// File: rtl/demux_l1_2x.sv
// rtl/demux_l1_2x.sv - L1 receive-side 2:1 byte-lane demultiplexer
//
// Splits one fast-rate interleaved byte stream back into lane 0 and lane 1
// at half rate. The lane slot is tracked by a free-running phase toggle; the
// lane 0 half is held for one cycle, then both halves are loaded onto the
// outputs on the same edge and held for one half-rate period (2 cycles).
//
// Ports:
//   clk_2f      in   1      sole clock, fast (2x) rate
//   reset       in   1      synchronous, active-high reset
//   data_in     in   WIDTH  interleaved input byte
//   valid_in    in   1      data_in qualifier
//   data_0      out  WIDTH  lane 0 byte
//   valid_0     out  1      lane 0 qualifier
//   data_1      out  WIDTH  lane 1 byte
//   valid_1     out  1      lane 1 qualifier
//   pair_stb    out  1      one-cycle pulse when a new pair is loaded
//   phase       out  1      current lane slot (0 = lane 0, 1 = lane 1)
//   orphan_cnt  out  CNT_W  saturating count of half-valid pairs

module demux_l1_2x #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] data_0,
   output logic             valid_0,
   output logic [WIDTH-1:0] data_1,
   output logic             valid_1,
   output logic             pair_stb,
   output logic             phase,
   output logic [CNT_W-1:0] orphan_cnt
);

   // Lane 0 half of the pair currently being assembled.
   logic [WIDTH-1:0] hold0;
   logic             hv0;

   // Exactly one half of the pair is valid.
   logic             orphan;
   logic             cnt_full;

   assign orphan   = hv0 ^ valid_in;
   assign cnt_full = (orphan_cnt == {CNT_W{1'b1}});

   // Free-running slot toggle; first cycle after reset is the lane 0 slot.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         phase <= 1'b0;
      end else begin
         phase <= ~phase;
      end
   end

   // Lane 0 slot capture. An invalid slot clears the qualifier but keeps the
   // old byte so a later stale load never exposes an unqualified value.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         hold0 <= '0;
         hv0   <= 1'b0;
      end else if (!phase) begin
         hv0 <= valid_in;
         if (valid_in) begin
            hold0 <= data_in;
         end
      end
   end

   // Output load at the end of each lane 1 slot. The lane 1 byte is taken
   // straight from the input, so both halves appear on the same edge.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         data_0   <= '0;
         valid_0  <= 1'b0;
         data_1   <= '0;
         valid_1  <= 1'b0;
         pair_stb <= 1'b0;
      end else if (phase) begin
         valid_0  <= hv0;
         valid_1  <= valid_in;
         pair_stb <= 1'b1;
         if (hv0) begin
            data_0 <= hold0;
         end
         if (valid_in) begin
            data_1 <= data_in;
         end
      end else begin
         pair_stb <= 1'b0;
      end
   end

   // Diagnostic count of pairs with exactly one valid half; saturates.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         orphan_cnt <= '0;
      end else if (phase && orphan && !cnt_full) begin
         orphan_cnt <= orphan_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_demux_l1_2x.sv
// tb/tb_demux_l1_2x.sv - self-checking bench for demux_l1_2x

module tb_demux_l1_2x;

   logic       clk_2f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic [7:0] data_0;
   logic       valid_0;
   logic [7:0] data_1;
   logic       valid_1;
   logic       pair_stb;
   logic       phase;
   logic [7:0] orphan_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk_2f = ~clk_2f;

   demux_l1_2x #(.WIDTH(8), .CNT_W(8)) dut (
      .clk_2f     (clk_2f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .data_0     (data_0),
      .valid_0    (valid_0),
      .data_1     (data_1),
      .valid_1    (valid_1),
      .pair_stb   (pair_stb),
      .phase      (phase),
      .orphan_cnt (orphan_cnt)
   );

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] d;
      logic       ev0;
      logic [7:0] ed0;
      logic       ev1;
      logic [7:0] ed1;
      logic       estb;
      logic       eph;
      logic [7:0] ecnt;
   } vec_t;

   localparam int NVEC = 18;
   vec_t tbl [NVEC];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle, then sample 1 ns after the active edge.
   task automatic step(input logic r, input logic v, input logic [7:0] d);
      reset    = r;
      valid_in = v;
      data_in  = d;
      @(posedge clk_2f);
      #1;
   endtask

   initial begin
      logic       lb_idle;
      logic [7:0] lb_a;
      logic [7:0] lb_b;
      int         exp_cnt;

      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;

      //          rst  v     d      ev0   ed0    ev1   ed1    stb   ph    cnt
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
      tbl[3]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h10, 1'b1, 8'h11, 1'b1, 1'b0, 8'd0};
      tbl[4]  = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h10, 1'b1, 8'h11, 1'b0, 1'b1, 8'd0};
      tbl[5]  = '{1'b0, 1'b1, 8'h21, 1'b1, 8'h20, 1'b1, 8'h21, 1'b1, 1'b0, 8'd0};
      tbl[6]  = '{1'b0, 1'b1, 8'h33, 1'b1, 8'h20, 1'b1, 8'h21, 1'b0, 1'b1, 8'd0};
      tbl[7]  = '{1'b0, 1'b0, 8'h99, 1'b1, 8'h33, 1'b0, 8'h21, 1'b1, 1'b0, 8'd1};
      tbl[8]  = '{1'b0, 1'b0, 8'h55, 1'b1, 8'h33, 1'b0, 8'h21, 1'b0, 1'b1, 8'd1};
      tbl[9]  = '{1'b0, 1'b0, 8'h66, 1'b0, 8'h33, 1'b0, 8'h21, 1'b1, 1'b0, 8'd1};
      tbl[10] = '{1'b0, 1'b0, 8'h77, 1'b0, 8'h33, 1'b0, 8'h21, 1'b0, 1'b1, 8'd1};
      tbl[11] = '{1'b0, 1'b0, 8'h88, 1'b0, 8'h33, 1'b0, 8'h21, 1'b1, 1'b0, 8'd1};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 8'h21, 1'b0, 1'b1, 8'd1};
      tbl[13] = '{1'b0, 1'b1, 8'h44, 1'b0, 8'h33, 1'b1, 8'h44, 1'b1, 1'b0, 8'd2};
      tbl[14] = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h33, 1'b1, 8'h44, 1'b0, 1'b1, 8'd2};
      tbl[15] = '{1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
      tbl[16] = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
      tbl[17] = '{1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 8'd0};

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].rst, tbl[i].v, tbl[i].d);
         check($sformatf("vec%0d valid_0", i), int'(valid_0), int'(tbl[i].ev0));
         check($sformatf("vec%0d data_0", i), int'(data_0), int'(tbl[i].ed0));
         check($sformatf("vec%0d valid_1", i), int'(valid_1), int'(tbl[i].ev1));
         check($sformatf("vec%0d data_1", i), int'(data_1), int'(tbl[i].ed1));
         check($sformatf("vec%0d pair_stb", i), int'(pair_stb), int'(tbl[i].estb));
         check($sformatf("vec%0d phase", i), int'(phase), int'(tbl[i].eph));
         check($sformatf("vec%0d orphan_cnt", i), int'(orphan_cnt), int'(tbl[i].ecnt));
      end

      // Saturation: 2^8+3 orphan pairs, count must stop at 255.
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 259; i++) begin
         step(1'b0, 1'b1, 8'(i));
         step(1'b0, 1'b0, 8'hEE);
         exp_cnt = (i + 1 > 255) ? 255 : i + 1;
         if (i >= 250 || i == 0) begin
            check($sformatf("sat%0d orphan_cnt", i), int'(orphan_cnt), exp_cnt);
            check($sformatf("sat%0d data_0", i), int'(data_0), i & 8'hFF);
         end
      end

      // Loopback from a phase-aligned 2:1 mux model, ~30% idle pairs.
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 200; i++) begin
         lb_idle = ($urandom_range(0, 9) < 3);
         lb_a    = 8'($urandom);
         lb_b    = 8'($urandom);
         check($sformatf("lb%0d phase0", i), int'(phase), 0);
         step(1'b0, !lb_idle, lb_a);
         step(1'b0, !lb_idle, lb_b);
         check($sformatf("lb%0d pair_stb", i), int'(pair_stb), 1);
         check($sformatf("lb%0d valid_0", i), int'(valid_0), int'(!lb_idle));
         check($sformatf("lb%0d valid_1", i), int'(valid_1), int'(!lb_idle));
         if (!lb_idle) begin
            check($sformatf("lb%0d data_0", i), int'(data_0), int'(lb_a));
            check($sformatf("lb%0d data_1", i), int'(data_1), int'(lb_b));
         end
      end
      check("lb orphan_cnt", int'(orphan_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
